// File: rtl/jk_excite_gen.sv
// jk_excite_gen: queues target bits for an external JK flip-flop, drives the
// J/K excitation needed to reach each target, then checks the stage's Q.
// Optional build macro JK_TOGGLE_EN: every transition uses toggle excitation
// (j=k=1); without it the classic set/reset excitation table is used.
module jk_excite_gen #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             q_fb,
    input  logic             clr_err,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    state_t           state;
    logic             tgt;
    logic             q_model;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

    // Excitation that moves a JK stage from cur to nxt.
    function automatic logic [1:0] excite(input logic cur, input logic nxt);
`ifdef JK_TOGGLE_EN
        return (cur != nxt) ? 2'b11 : 2'b00;
`else
        if (cur == nxt)
            return 2'b00;
        else
            return nxt ? 2'b10 : 2'b01;
`endif
    endfunction

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push     = in_valid && !full;
    // The FSM takes a new target whenever it is not mid-drive.
    assign pop      = !empty && ((state == IDLE) || (state == CHECK));
    assign head     = mem[rd_ptr];
    assign in_ready = !full;
    assign busy     = (state != IDLE) || !empty;

    // FIFO storage: written on push only.
    // NOTE: the data array carries no reset; occupancy is tracked by count, so
    // stale bits are never read and the array maps onto plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_bit;
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Control FSM with registered excitation outputs and expected-Q model.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt     <= 1'b0;
            q_model <= 1'b0;
            j       <= 1'b0;
            k       <= 1'b0;
        end else begin
            j <= 1'b0;
            k <= 1'b0;
            unique case (state)
                IDLE, CHECK: begin
                    if (pop) begin
                        tgt    <= head;
                        {j, k} <= excite(q_model, head);
                        state  <= DRIVE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                DRIVE: begin
                    q_model <= tgt;
                    state   <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flag and saturating mismatch counter; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (clr_err) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if ((state == CHECK) && (q_fb != tgt)) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_excite_gen.sv
// tb_jk_excite_gen: scoreboard bench for jk_excite_gen. Each accepted target is
// pushed with its expected excitation; a cycle model pops it when the drive
// should start and every output is compared on the falling edge.
module tb_jk_excite_gen;

    localparam int DEPTH    = 4;
    localparam int CNT_W    = 2;
    localparam int ECNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_ready;
    logic             q_fb;
    logic             clr_err = 1'b0;
    logic             j;
    logic             k;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    jk_excite_gen #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .q_fb(q_fb), .clr_err(clr_err), .j(j), .k(k),
        .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // External JK stage driven by the DUT, optionally forced to read 0.
    logic jk_q = 1'b0;
    logic tie_zero = 1'b0;
    assign q_fb = tie_zero ? 1'b0 : jk_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            jk_q <= 1'b0;
        else
            case ({j, k})
                2'b10:   jk_q <= 1'b1;
                2'b01:   jk_q <= 1'b0;
                2'b11:   jk_q <= ~jk_q;
                default: jk_q <= jk_q;
            endcase
    end

    function automatic logic [1:0] exc(input logic cur, input logic nxt);
`ifdef JK_TOGGLE_EN
        return (cur != nxt) ? 2'b11 : 2'b00;
`else
        if (cur == nxt) return 2'b00;
        return nxt ? 2'b10 : 2'b01;
`endif
    endfunction

    typedef struct packed {logic tgt; logic j; logic k;} item_t;

    item_t sb[$];
    item_t cur = '0;
    int    m_cnt = 0;
    int    m_phase = 0;  // 0 idle, 1 drive, 2 check
    logic  m_err = 1'b0;
    int    m_ecnt = 0;
    logic  last_tgt = 1'b0;
    bit    m_push;
    bit    m_pop;

    // Reference cycle model / scoreboard update on each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_phase = 0; m_err = 1'b0; m_ecnt = 0;
            last_tgt = 1'b0; cur = '0; sb.delete();
        end else begin
            m_push = in_valid && (m_cnt < DEPTH);
            m_pop  = (m_cnt > 0) && (m_phase != 1);
            if (clr_err) begin
                m_err = 1'b0; m_ecnt = 0;
            end else if (m_phase == 2 && q_fb !== cur.tgt) begin
                m_err = 1'b1;
                if (m_ecnt < ECNT_MAX) m_ecnt++;
            end
            if (m_pop) cur = sb.pop_front();
            if (m_push) begin
                item_t it;
                it.tgt = in_bit;
                {it.j, it.k} = exc(last_tgt, in_bit);
                sb.push_back(it);
                last_tgt = in_bit;
            end
            m_phase = (m_phase == 1) ? 2 : (m_pop ? 1 : 0);
            m_cnt   = m_cnt + int'(m_push) - int'(m_pop);
        end
    end

    logic [1:0] drv_log[$];
    bit         saw_full = 1'b0;

    // Compare every output on the falling edge.
    always @(negedge clk) begin
        check("j",        int'(j),        (m_phase == 1) ? int'(cur.j) : 0);
        check("k",        int'(k),        (m_phase == 1) ? int'(cur.k) : 0);
        check("in_ready", int'(in_ready), int'(m_cnt < DEPTH));
        check("busy",     int'(busy),     int'(m_phase != 0 || m_cnt > 0));
        check("err",      int'(err),      int'(m_err));
        check("err_cnt",  int'(err_cnt),  m_ecnt);
        if (m_phase == 1) drv_log.push_back({j, k});
        if (!in_ready) saw_full = 1'b1;
    end

    task automatic push_bits(input logic [15:0] bits, input int n);
        int tries;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = bits[i];
            tries    = 0;
            while (!in_ready && tries < 100) begin
                @(negedge clk);
                tries++;
            end
            if (tries == 100) check("push_timeout", 0, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int tries = 0;
        while ((m_phase != 0 || m_cnt != 0) && tries < 200) begin
            @(negedge clk);
            tries++;
        end
        if (tries == 200) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    logic [1:0] seq_exp [5];

    initial begin
`ifdef JK_TOGGLE_EN
        seq_exp = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00};
`else
        seq_exp = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", int'(in_ready), 1);
        check("rst_busy",  int'(busy),     0);
        rst_n = 1'b1;

        // Sequence 1,0,0,1,1 with JK loopback (LSB first).
        drv_log.delete();
        push_bits(16'b11001, 5);
        wait_idle();
        check("seq_drives", drv_log.size(), 5);
        for (int i = 0; i < 5 && i < drv_log.size(); i++)
            check($sformatf("seq_jk%0d", i), int'(drv_log[i]), int'(seq_exp[i]));
        check("seq_err", int'(err), 0);

        // Single mismatch, then clear.
        tie_zero = 1'b1;
        push_bits(16'b0, 1);
        push_bits(16'b1, 1);
        wait_idle();
        check("mm_err",  int'(err),     1);
        check("mm_cnt",  int'(err_cnt), 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", int'(err),     0);
        check("clr_cnt", int'(err_cnt), 0);

        // Saturation: five forced mismatches on a 2-bit counter.
        push_bits(16'b11111, 5);
        wait_idle();
        check("sat_cnt", int'(err_cnt), ECNT_MAX);
        check("sat_err", int'(err),     1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err  = 1'b0;
        tie_zero = 1'b0;

        // Back-to-back pushes until the FIFO fills; order kept by scoreboard.
        drv_log.delete();
        saw_full = 1'b0;
        push_bits(16'b0110_1010_0110, 12);
        wait_idle();
        check("full_seen",   int'(saw_full), 1);
        check("full_drives", drv_log.size(), 12);
        check("full_err",    int'(err),      0);

        // Asynchronous reset while driving, with a nonzero error count.
        tie_zero = 1'b1;
        push_bits(16'b11111, 5);
        begin
            int tries = 0;
            while (!(m_phase == 1 && m_ecnt > 0) && tries < 100) begin
                @(negedge clk);
                tries++;
            end
            if (tries == 100) check("drive_timeout", 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_j",     int'(j),        0);
        check("arst_k",     int'(k),        0);
        check("arst_cnt",   int'(err_cnt),  0);
        check("arst_err",   int'(err),      0);
        check("arst_ready", int'(in_ready), 1);
        check("arst_busy",  int'(busy),     0);
        tie_zero = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset: nothing stale is driven or checked.
        drv_log.delete();
        push_bits(16'b01, 2);
        wait_idle();
        check("post_drives", drv_log.size(), 2);
        check("post_err",    int'(err),      0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
